mac_vector_sequencer: RTL and testbench

Upstream operand sequencer for the 8-bit Wallace/prefix-adder MAC. Accepts a job (vector length), streams operand pairs from a valid/ready source into the MAC's `a`/`b`/`cin` inputs, clears the MAC accumulator at job start, and drives zeros whenever no operand is available. After the pipeline drains, it captures the MAC's `{cout, out}` as a 17-bit dot-product result and presents it on a valid/ready result port.

---
 rtl/mac_vector_sequencer.sv | 85 ++++++++
 tb/tb_mac_vector_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mac_vector_sequencer.sv
// mac_vector_sequencer: streams operand pairs into a MAC and returns the 17-bit dot product
module mac_vector_sequencer #(
    parameter int MAC_LATENCY = 1,
    parameter int LEN_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    output logic             mac_cin,
    output logic             mac_rst,
    input  logic [15:0]      mac_out,
    input  logic             mac_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [16:0]      res_data
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    localparam int DW = $clog2(MAC_LATENCY + 2);
    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [DW-1:0] D_ONE = 1;
    localparam logic [DW-1:0] D_LAST = DW'(MAC_LATENCY);

    state_t           state, next_state;
    logic [LEN_W-1:0] cnt, len_q;
    logic [DW-1:0]    dcnt;
    logic             fire, feed_last, drain_last;

    // next-state decode and state-derived outputs
    always_comb begin
        next_state = state;
        busy       = state != IDLE;
        in_ready   = state == FEED;
        res_valid  = state == DONE;
        mac_rst    = rst || state == CLEAR;
        mac_cin    = 1'b0;
        fire       = in_ready && in_valid;
        feed_last  = fire && (cnt + LEN_ONE == len_q);
        drain_last = state == DRAIN && dcnt == D_LAST;
        case (state)
            IDLE:    next_state = (start && len != '0) ? CLEAR : IDLE;
            CLEAR:   next_state = FEED;
            FEED:    next_state = feed_last ? DRAIN : FEED;
            DRAIN:   next_state = drain_last ? DONE : DRAIN;
            DONE:    next_state = res_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    // state, counters, registered MAC operands and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            err      <= 1'b0;
            cnt      <= '0;
            len_q    <= '0;
            dcnt     <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            res_data <= '0;
        end else begin
            state <= next_state;
            err   <= state == IDLE && start && len == '0;
            if (state == IDLE && start) begin
                len_q <= len;
                cnt   <= '0;
            end else if (fire) begin
                cnt <= cnt + LEN_ONE;
            end
            mac_a <= fire ? in_a : '0;
            mac_b <= fire ? in_b : '0;
            dcnt  <= state == DRAIN ? dcnt + D_ONE : '0;
            if (drain_last) res_data <= {mac_cout, mac_out};
        end
    end
endmodule

// File: tb/tb_mac_vector_sequencer.sv
// tb_mac_vector_sequencer: directed checks of the MAC operand sequencer against a behavioural MAC
module tb_mac_vector_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        busy, err, in_ready;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [7:0]  mac_a, mac_b;
    logic        mac_cin, mac_rst;
    logic [15:0] mac_out;
    logic        mac_cout;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [16:0] res_data;

    logic [16:0] acc;
    logic [15:0] prod;
    logic [7:0]  va[8], vb[8];
    logic [16:0] res;
    int          n_tests = 0, n_fail = 0;

    mac_vector_sequencer #(.MAC_LATENCY(1), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_cin(mac_cin), .mac_rst(mac_rst),
        .mac_out(mac_out), .mac_cout(mac_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // behavioural single-cycle MAC accumulator
    assign prod = 16'(mac_a) * 16'(mac_b);
    always @(posedge clk) acc <= mac_rst ? 17'd0 : acc + {1'b0, prod} + {16'd0, mac_cin};
    assign mac_out  = acc[15:0];
    assign mac_cout = acc[16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_job(input int n, input bit bub, input bit take, output logic [16:0] r);
        int  i = 0, k = 0;
        bit  tog = 1'b0, fired, rdy;
        start = 1'b1;
        len   = 8'(n);
        tick;
        start = 1'b0;
        chk("clear_mac_rst", {31'd0, mac_rst}, 1);
        chk("clear_busy", {31'd0, busy}, 1);
        chk("clear_in_ready", {31'd0, in_ready}, 0);
        while (i < n && k < 100) begin
            in_valid = bub ? tog : 1'b1;
            in_a  = va[i];
            in_b  = vb[i];
            rdy   = in_ready;
            fired = in_valid && in_ready;
            tick;
            if (fired) i++;
            if (rdy && !fired) begin
                chk("bubble_mac_a", {24'd0, mac_a}, 0);
                chk("bubble_mac_b", {24'd0, mac_b}, 0);
            end
            tog = ~tog;
            k++;
        end
        chk("feed_count", i, n);
        in_valid = 1'b0;
        k = 0;
        while (!res_valid && k < 20) begin
            tick;
            k++;
        end
        chk("res_valid_seen", {31'd0, res_valid}, 1);
        r = res_data;
        if (take) begin
            res_ready = 1'b1;
            tick;
            res_ready = 1'b0;
            chk("res_valid_drop", {31'd0, res_valid}, 0);
            chk("busy_after", {31'd0, busy}, 0);
        end
    endtask

    initial begin
        tick;
        tick;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_mac_a", {24'd0, mac_a}, 0);
        chk("rst_mac_b", {24'd0, mac_b}, 0);
        chk("rst_mac_cin", {31'd0, mac_cin}, 0);
        chk("rst_mac_rst", {31'd0, mac_rst}, 1);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_res_data", {15'd0, res_data}, 0);
        rst = 1'b0;
        tick;
        chk("idle_mac_rst", {31'd0, mac_rst}, 0);

        va[0] = 12; vb[0] = 15; va[1] = 8; vb[1] = 10;
        va[2] = 25; vb[2] = 30; va[3] = 100; vb[3] = 50;
        do_job(4, 1'b0, 1'b1, res);
        chk("job4_res", {15'd0, res}, 6010);
        chk("job4_cout", {31'd0, res[16]}, 0);

        va[0] = 255; vb[0] = 255; va[1] = 255; vb[1] = 255;
        do_job(2, 1'b0, 1'b1, res);
        chk("sat_res", {15'd0, res}, 32'h1FC02);

        va[0] = 1; vb[0] = 1; va[1] = 2; vb[1] = 2; va[2] = 3; vb[2] = 3;
        do_job(3, 1'b1, 1'b1, res);
        chk("bubble_res", {15'd0, res}, 14);

        start = 1'b1;
        len   = 8'd0;
        tick;
        start = 1'b0;
        chk("len0_err", {31'd0, err}, 1);
        chk("len0_busy", {31'd0, busy}, 0);
        chk("len0_mac_rst", {31'd0, mac_rst}, 0);
        tick;
        chk("len0_err_clr", {31'd0, err}, 0);
        chk("len0_busy2", {31'd0, busy}, 0);

        start = 1'b1;
        len   = 8'd5;
        tick;
        start = 1'b0;
        tick;
        in_valid = 1'b1;
        in_a = 8'd20;
        in_b = 8'd30;
        tick;
        tick;
        rst = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_err", {31'd0, err}, 0);
        chk("abort_in_ready", {31'd0, in_ready}, 0);
        chk("abort_mac_a", {24'd0, mac_a}, 0);
        chk("abort_mac_rst", {31'd0, mac_rst}, 1);
        chk("abort_res_valid", {31'd0, res_valid}, 0);
        chk("abort_res_data", {15'd0, res_data}, 0);
        rst = 1'b0;
        tick;
        va[0] = 7; vb[0] = 9;
        do_job(1, 1'b0, 1'b1, res);
        chk("after_abort_res", {15'd0, res}, 63);

        va[0] = 3; vb[0] = 4; va[1] = 5; vb[1] = 6;
        do_job(2, 1'b0, 1'b0, res);
        chk("hold_res", {15'd0, res}, 42);
        for (int c = 0; c < 10; c++) begin
            start = c[0];
            len   = 8'd3;
            tick;
            chk("hold_valid", {31'd0, res_valid}, 1);
            chk("hold_data", {15'd0, res_data}, 42);
        end
        start = 1'b1;
        res_ready = 1'b1;
        tick;
        start = 1'b0;
        res_ready = 1'b0;
        chk("hold_release_valid", {31'd0, res_valid}, 0);
        chk("hold_release_busy", {31'd0, busy}, 0);
        tick;
        chk("start_in_done_ignored", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
